// File: rtl/store_narrow_merge.sv
// Store-path byte merger: read-modify-write for narrow stores,
// direct write for doubleword stores, misalignment fault pulse.
module store_narrow_merge #(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [63:0]       mem_rd_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [63:0]       mem_wr_data,
   output logic              done,
   output logic              misalign_err
);

   typedef enum logic [2:0] {
      IDLE, RD, WAIT, WR, ERR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       data_q;
   logic [1:0]        size_q;

   logic [2:0]        amask;
   logic              misal;
   logic              dbl;
   logic [ADDR_W-1:0] req_al;
   logic [ADDR_W-1:0] addr_al;
   logic [63:0]       smask;
   logic [5:0]        sh;
   logic [63:0]       merged;

   always_comb begin
      amask = 3'b111;
      unique case (req_size)
         2'b00:   amask = 3'b000;
         2'b01:   amask = 3'b001;
         2'b10:   amask = 3'b011;
         default: amask = 3'b111;
      endcase
   end

   always_comb begin
      smask = '1;
      unique case (size_q)
         2'b00:   smask = 64'h0000_0000_0000_00ff;
         2'b01:   smask = 64'h0000_0000_0000_ffff;
         2'b10:   smask = 64'h0000_0000_ffff_ffff;
         default: smask = '1;
      endcase
   end

   assign misal   = |(req_addr[2:0] & amask);
   assign dbl     = (req_size == 2'b11) & ~misal;
   assign req_al  = {req_addr[ADDR_W-1:3], 3'b000};
   assign addr_al = {addr_q[ADDR_W-1:3], 3'b000};
   assign sh      = {addr_q[2:0], 3'b000};

   // Low size bytes of the store data land at the byte offset.
   assign merged = (mem_rd_data & ~(smask << sh))
                 | ((data_q & smask) << sh);

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         size_q       <= '0;
         mem_rd_en    <= 1'b0;
         mem_rd_addr  <= '0;
         mem_wr_en    <= 1'b0;
         mem_wr_addr  <= '0;
         mem_wr_data  <= '0;
         done         <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  data_q <= req_data;
                  size_q <= req_size;
                  unique case (1'b1)
                     misal: begin
                        state        <= ERR;
                        done         <= 1'b1;
                        misalign_err <= 1'b1;
                     end
                     dbl: begin
                        state       <= WR;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= req_al;
                        mem_wr_data <= req_data;
                        done        <= 1'b1;
                     end
                     default: begin
                        state       <= RD;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= req_al;
                     end
                  endcase
               end
            end
            RD: begin
               state       <= WAIT;
               mem_rd_en   <= 1'b0;
               mem_rd_addr <= '0;
            end
            WAIT: begin
               state       <= WR;
               mem_wr_en   <= 1'b1;
               mem_wr_addr <= addr_al;
               mem_wr_data <= merged;
               done        <= 1'b1;
            end
            WR: begin
               state       <= IDLE;
               mem_wr_en   <= 1'b0;
               mem_wr_addr <= '0;
               mem_wr_data <= '0;
               done        <= 1'b0;
            end
            ERR: begin
               state        <= IDLE;
               done         <= 1'b0;
               misalign_err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_narrow_merge.sv
// Self-checking bench for store_narrow_merge with a
// byte-level reference model and a registered memory.
module tb_store_narrow_merge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_addr = '0;
   logic [63:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        mem_rd_en;
   logic [63:0] mem_rd_addr;
   logic [63:0] mem_rd_data = '0;
   logic        mem_wr_en;
   logic [63:0] mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic        done;
   logic        misalign_err;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_count = 0;
   int done_count = 0;

   logic [63:0] mem     [0:63];
   logic [63:0] ref_mem [0:63];

   logic        t_rd   [1:8];
   logic [63:0] t_rda  [1:8];
   logic        t_wr   [1:8];
   logic [63:0] t_wra  [1:8];
   logic [63:0] t_wrd  [1:8];
   logic        t_done [1:8];
   logic        t_err  [1:8];
   logic        t_rdy  [1:8];

   store_narrow_merge #(.ADDR_W(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_size     (req_size),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .done         (done),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[8:3]];
      if (mem_wr_en) mem[mem_wr_addr[8:3]] <= mem_wr_data;
   end

   always @(negedge clk) begin
      if (mem_wr_en) wr_count++;
      if (done) done_count++;
   end

   function automatic logic [63:0] exp_merge(
      input logic [63:0] old, input logic [63:0] a,
      input logic [63:0] d, input logic [1:0] s);
      int n, o;
      logic [63:0] r;
      n = 1 << s;
      o = int'(a[2:0]);
      r = old;
      for (int k = 0; k < n; k++) r[8*(o+k) +: 8] = d[8*k +: 8];
      return r;
   endfunction

   task automatic capture(input int k);
      t_rd[k]   = mem_rd_en;
      t_rda[k]  = mem_rd_addr;
      t_wr[k]   = mem_wr_en;
      t_wra[k]  = mem_wr_addr;
      t_wrd[k]  = mem_wr_data;
      t_done[k] = done;
      t_err[k]  = misalign_err;
      t_rdy[k]  = req_ready;
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] s);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_ready_timeout got=%0b want=1", req_ready);
      end
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = s;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      req_data  = {$urandom, $urandom};
      req_size  = 2'($urandom);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         capture(k);
      end
   endtask

   task automatic test_reset;
      logic [63:0] z;
      z = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got=%0b want=1", req_ready);
      end
      n_tests++;
      if ({mem_rd_en, mem_wr_en, done, misalign_err} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_strobes got=%b want=0000",
                  {mem_rd_en, mem_wr_en, done, misalign_err});
      end
      n_tests++;
      if ({mem_rd_addr, mem_wr_addr, mem_wr_data} !== {z, z, z}) begin
         n_fail++;
         $display("FAIL reset_buses got=%h/%h/%h want=0",
                  mem_rd_addr, mem_wr_addr, mem_wr_data);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_byte_offset5;
      logic [63:0] e;
      mem[8] = 64'h1122334455667788;
      ref_mem[8] = 64'h1122334455667788;
      issue(64'h45, 64'hFFFFFFFFFFFFFFAB, 2'b00);
      e = exp_merge(ref_mem[8], 64'h45, 64'hFFFFFFFFFFFFFFAB, 2'b00);
      ref_mem[8] = e;
      n_tests++;
      if (!(t_rd[1] === 1'b1 && t_rda[1] === 64'h40 &&
            t_rd[2] === 1'b0 && t_rd[3] === 1'b0)) begin
         n_fail++;
         $display("FAIL byte_rd en1=%b a1=%h en2=%b want 1/40/0",
                  t_rd[1], t_rda[1], t_rd[2]);
      end
      n_tests++;
      if (!(t_wr[3] === 1'b1 && t_wra[3] === 64'h40 &&
            t_wrd[3] === 64'h1122AB4455667788 && e === t_wrd[3])) begin
         n_fail++;
         $display("FAIL byte_wr en=%b a=%h d=%h want 1/40/1122ab4455667788",
                  t_wr[3], t_wra[3], t_wrd[3]);
      end
      n_tests++;
      if ({t_done[1], t_done[2], t_done[3], t_done[4]} !== 4'b0010 ||
          t_rdy[3] !== 1'b0 || t_rdy[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL byte_done done=%b rdy3=%b rdy4=%b want 0010/0/1",
                  {t_done[1], t_done[2], t_done[3], t_done[4]},
                  t_rdy[3], t_rdy[4]);
      end
   endtask

   task automatic test_word_upper;
      mem[8] = 64'h1122334455667788;
      ref_mem[8] = 64'h1122334455667788;
      issue(64'h44, 64'h00000000DEADBEEF, 2'b10);
      ref_mem[8] = exp_merge(ref_mem[8], 64'h44, 64'hDEADBEEF, 2'b10);
      n_tests++;
      if (t_wr[3] !== 1'b1 || t_wrd[3] !== 64'hDEADBEEF55667788) begin
         n_fail++;
         $display("FAIL word_upper en=%b d=%h want 1/deadbeef55667788",
                  t_wr[3], t_wrd[3]);
      end
   endtask

   task automatic test_double;
      logic any_rd;
      issue(64'h80, 64'h0123456789ABCDEF, 2'b11);
      ref_mem[16] = 64'h0123456789ABCDEF;
      any_rd = 1'b0;
      for (int k = 1; k <= 8; k++) any_rd |= t_rd[k];
      n_tests++;
      if (any_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL double_no_rd got=%b want=0", any_rd);
      end
      n_tests++;
      if (!(t_wr[1] === 1'b1 && t_done[1] === 1'b1 && t_wra[1] === 64'h80 &&
            t_wrd[1] === 64'h0123456789ABCDEF && t_rdy[2] === 1'b1 &&
            t_wr[2] === 1'b0)) begin
         n_fail++;
         $display("FAIL double_wr en=%b done=%b a=%h d=%h rdy2=%b",
                  t_wr[1], t_done[1], t_wra[1], t_wrd[1], t_rdy[2]);
      end
   endtask

   task automatic test_misaligned;
      logic any_mem;
      issue(64'h43, 64'h1234, 2'b01);
      any_mem = 1'b0;
      for (int k = 1; k <= 8; k++) any_mem |= t_rd[k] | t_wr[k];
      n_tests++;
      if (!(t_done[1] === 1'b1 && t_err[1] === 1'b1 &&
            t_done[2] === 1'b0 && t_err[2] === 1'b0 && t_rdy[2] === 1'b1)) begin
         n_fail++;
         $display("FAIL misal_pulse done=%b err=%b done2=%b rdy2=%b",
                  t_done[1], t_err[1], t_done[2], t_rdy[2]);
      end
      n_tests++;
      if (any_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL misal_no_mem got=%b want=0", any_mem);
      end
   endtask

   task automatic test_reset_wait;
      int wc, dc;
      mem[8] = 64'h1122334455667788;
      ref_mem[8] = 64'h1122334455667788;
      @(negedge clk);
      wc = wr_count;
      dc = done_count;
      req_valid = 1'b1;
      req_addr  = 64'h45;
      req_data  = 64'hAB;
      req_size  = 2'b00;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if (!(req_ready === 1'b1 && mem_rd_en === 1'b0 && mem_wr_en === 1'b0 &&
            done === 1'b0 && misalign_err === 1'b0 && mem_rd_addr === 64'h0 &&
            mem_wr_addr === 64'h0 && mem_wr_data === 64'h0)) begin
         n_fail++;
         $display("FAIL rst_wait_async rdy=%b rd=%b wr=%b done=%b",
                  req_ready, mem_rd_en, mem_wr_en, done);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      n_tests++;
      if (wr_count !== wc || done_count !== dc || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_wait_dropped wr=%0d done=%0d want %0d/%0d rdy=%b",
                  wr_count, done_count, wc, dc, req_ready);
      end
      issue(64'h88, 64'hCAFEF00D12345678, 2'b11);
      ref_mem[17] = 64'hCAFEF00D12345678;
      n_tests++;
      if (!(t_wr[1] === 1'b1 && t_done[1] === 1'b1 && t_wra[1] === 64'h88 &&
            t_wrd[1] === 64'hCAFEF00D12345678)) begin
         n_fail++;
         $display("FAIL rst_wait_recover en=%b done=%b a=%h d=%h",
                  t_wr[1], t_done[1], t_wra[1], t_wrd[1]);
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] d1, d2, e1, e2;
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      e1 = exp_merge(ref_mem[2], 64'h10, d1, 2'b01);
      e2 = exp_merge(e1, 64'h16, d2, 2'b01);
      ref_mem[2] = e2;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 64'h10;
      req_data  = d1;
      req_size  = 2'b01;
      @(posedge clk);
      #1;
      req_addr = 64'h16;
      req_data = d2;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         capture(k);
         if (k == 4) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
         end
      end
      n_tests++;
      if ({t_rdy[1], t_rdy[2], t_rdy[3], t_rdy[4], t_rdy[5]} !== 5'b00010) begin
         n_fail++;
         $display("FAIL b2b_ready got=%b want=00010",
                  {t_rdy[1], t_rdy[2], t_rdy[3], t_rdy[4], t_rdy[5]});
      end
      n_tests++;
      if (!(t_wr[3] === 1'b1 && t_wra[3] === 64'h10 && t_wrd[3] === e1)) begin
         n_fail++;
         $display("FAIL b2b_wr1 en=%b a=%h d=%h want 1/10/%h",
                  t_wr[3], t_wra[3], t_wrd[3], e1);
      end
      n_tests++;
      if (!(t_wr[7] === 1'b1 && t_wra[7] === 64'h10 && t_wrd[7] === e2 &&
            t_wr[4] === 1'b0 && t_wr[5] === 1'b0 && t_wr[6] === 1'b0)) begin
         n_fail++;
         $display("FAIL b2b_wr2 en=%b a=%h d=%h want 1/10/%h",
                  t_wr[7], t_wra[7], t_wrd[7], e2);
      end
   endtask

   task automatic test_random;
      logic [63:0] a, d, e, al;
      logic [1:0]  s;
      int          n, idx, f0;
      logic        bad_addr, any_mem;
      for (int it = 0; it < 150; it++) begin
         a   = 64'($urandom_range(0, 511));
         d   = {$urandom, $urandom};
         s   = 2'($urandom);
         n   = 1 << s;
         idx = int'(a[8:3]);
         al  = {a[63:3], 3'b000};
         issue(a, d, s);
         f0 = n_fail;
         bad_addr = 1'b0;
         any_mem  = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            if (!t_rd[k] && t_rda[k] !== 64'h0) bad_addr = 1'b1;
            if (!t_wr[k] && t_wra[k] !== 64'h0) bad_addr = 1'b1;
            any_mem |= t_rd[k] | t_wr[k];
         end
         n_tests++;
         if (bad_addr) begin
            n_fail++;
            $display("FAIL rnd_idle_addr it=%0d addr nonzero with enable low",
                     it);
         end
         n_tests++;
         if (int'(a[2:0]) % n != 0) begin
            if (!(t_done[1] === 1'b1 && t_err[1] === 1'b1 && !any_mem)) begin
               n_fail++;
               $display("FAIL rnd_misal it=%0d a=%h s=%0d done=%b err=%b mem=%b",
                        it, a, s, t_done[1], t_err[1], any_mem);
            end
         end else if (s == 2'b11) begin
            ref_mem[idx] = d;
            if (!(t_wr[1] === 1'b1 && t_done[1] === 1'b1 && t_wra[1] === al &&
                  t_wrd[1] === d && t_err[1] === 1'b0)) begin
               n_fail++;
               $display("FAIL rnd_double it=%0d a=%h got=%h want=%h",
                        it, a, t_wrd[1], d);
            end
         end else begin
            e = exp_merge(ref_mem[idx], a, d, s);
            ref_mem[idx] = e;
            if (!(t_rd[1] === 1'b1 && t_rda[1] === al && t_wr[3] === 1'b1 &&
                  t_done[3] === 1'b1 && t_wra[3] === al && t_wrd[3] === e &&
                  t_err[3] === 1'b0 && t_rdy[4] === 1'b1)) begin
               n_fail++;
               $display("FAIL rnd_narrow it=%0d a=%h s=%0d got=%h want=%h",
                        it, a, s, t_wrd[3], e);
            end
         end
         if (n_fail != f0) break;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = {$urandom, $urandom};
         ref_mem[i] = mem[i];
      end
      test_reset;
      test_byte_offset5;
      test_word_upper;
      test_double;
      test_misaligned;
      test_reset_wait;
      test_back_to_back;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/store_narrow_merge.md
# store_narrow_merge

Store-side counterpart of the load-path zero extender in the pipelined CPU. It takes a 64-bit register value plus a byte address and access size from the MEM stage and writes only the addressed bytes into the doubleword-wide data memory. For byte, half and word stores it does a read-modify-write; doubleword stores go straight to memory. It is a multi-cycle unit, and the pipeline stalls on `req_ready` low.

## Interface
Parameters:
- `ADDR_W`, default 64: byte-address width. Memory doubleword index is `addr[ADDR_W-1:3]`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit idle, can accept a request.
- `req_addr`  in  ADDR_W  byte address.
- `req_data`  in  64  register value; only the low `size` bytes are stored.
- `req_size`  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = double.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_rd_addr`  out  ADDR_W  doubleword-aligned read address.
- `mem_rd_data`  in  64  read data, valid the cycle after `mem_rd_en` (registered memory).
- `mem_wr_en`  out  1  memory write strobe (full 64-bit write).
- `mem_wr_addr`  out  ADDR_W  doubleword-aligned write address.
- `mem_wr_data`  out  64  merged write data.
- `done`  out  1  one-cycle pulse when the request completes, whether written or faulted.
- `misalign_err`  out  1  one-cycle pulse together with `done` for a misaligned request.

## Operation
- **States:** IDLE, RD, WAIT, WR, ERR.
- **IDLE:**
  - `req_ready`=1.
  - A handshake (`req_valid & req_ready`) latches addr, data and size.
  - `req_valid` is ignored while `reset` is low.
- **Next-state decode on accept:**
  - Misaligned (`addr[2:0]` not a multiple of 2^size) → ERR.
  - size=11 and aligned → WR, with merged data = `req_data`.
  - Otherwise → RD.
- **RD:**
  - `mem_rd_en`=1.
  - `mem_rd_addr` = `{addr[ADDR_W-1:3],3'b000}`.
  - → WAIT.
- **WAIT:**
  - `mem_rd_data` is valid.
  - Merged data is registered: bytes `o .. o+2^size-1` (o = `addr[2:0]`, little-endian) are replaced with bytes `0 .. 2^size-1` of `req_data`.
  - All other bytes come from `mem_rd_data`.
  - → WR.
- **WR:**
  - `mem_wr_en`=1, `done`=1.
  - `mem_wr_addr` = aligned address; `mem_wr_data` = merged register.
  - → IDLE.
- **ERR:**
  - `done`=1, `misalign_err`=1.
  - No memory access.
  - → IDLE.
- **Output rules:**
  - Upper bytes of `req_data` beyond the size are never written.
  - `mem_*` addresses are 0 whenever the matching enable is 0.

## Timing
- **Reset values:**
  - state IDLE, `req_ready`=1.
  - `mem_rd_en`, `mem_wr_en`, `done`, `misalign_err` = 0.
  - All address/data outputs = 0.
- **Reset mid-operation:** returns to IDLE immediately (asynchronous). The latched request is dropped, and no write or `done` is issued for it.
- **Latency, counted from the accept cycle = 0:**
  - Narrow store: RD cycle 1, WAIT cycle 2, WR + `done` cycle 3, `req_ready` again cycle 4.
  - Double store: WR + `done` cycle 1, ready cycle 2.
  - Misaligned: ERR + `done` cycle 1, ready cycle 2.
- **Back-to-back:** no back-to-back accept; at least one IDLE cycle between requests.
- **Request stability:** `req_*` inputs may change after the accept cycle without effect.
- **Registered outputs:** all outputs are registered or pure state decodes; there is no combinational path from `req_*` to `mem_*`.

## Test plan
- **Byte store, offset 5:**
  - Stimulus: memory[0x40] = 0x1122334455667788; store size 00, addr 0x45, data 0xFFFFFFFFFFFFFFAB.
  - Required: `mem_rd_en` cycle 1 addr 0x40; `mem_wr_en` cycle 3 addr 0x40, data 0x1122AB4455667788; `done` cycle 3 only.
- **Word store, upper half:**
  - Stimulus: same memory value; size 10, addr 0x44, data 0xDEADBEEF.
  - Required: write data 0xDEADBEEF55667788.
- **Double store:**
  - Stimulus: addr 0x80, data 0x0123456789ABCDEF.
  - Required: no `mem_rd_en`; `mem_wr_en` + `done` cycle 1, data unchanged; `req_ready` high cycle 2.
- **Misaligned half:**
  - Stimulus: size 01, addr 0x43.
  - Required: `done` and `misalign_err` cycle 1; `mem_rd_en`/`mem_wr_en` stay 0 throughout.
- **Reset in WAIT:**
  - Stimulus: start byte store; pull `reset` low during cycle 2.
  - Required: all outputs reset immediately; no `mem_wr_en` or `done` ever; after release `req_ready`=1 and a new double store completes normally.
- **Back-to-back valid:**
  - Stimulus: `req_valid` held high with two half stores (addr 0x10, then 0x16).
  - Required: second accepted cycle 4; writes at cycles 3 and 7, to addr 0x10 with bytes 0–1 merged and to 0x10 with bytes 6–7 merged.
